sp_ram_copy_dma: RTL

//  Initiator for one sp_ram port: copies LEN consecutive words from a source byte address to a

---
 rtl/sp_ram_copy_dma.sv | 124 ++++++++++++
 1 files changed

// File: rtl/sp_ram_copy_dma.sv
// Background block-copy engine for one single-port RAM port: copies len words from an
// aligned source to an aligned destination, one read then one write per word.
module sp_ram_copy_dma #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  logic [ADDR_WIDTH-1:0]   src_addr_i,
    input  logic [ADDR_WIDTH-1:0]   dst_addr_i,
    input  logic [LEN_WIDTH-1:0]    len_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [LEN_WIDTH-1:0]    words_o,
    output logic                    mem_en_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    output logic                    mem_we_o,
    output logic [DATA_WIDTH/8-1:0] mem_be_o,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

    localparam int BPW = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] STEP       = ADDR_WIDTH'(BPW);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'(BPW - 1));

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        FIN
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] src_ptr;
    logic [ADDR_WIDTH-1:0] dst_ptr;
    logic [LEN_WIDTH-1:0]  len_reg;
    logic [LEN_WIDTH-1:0]  words;
    logic                  last_word;

    // The write about to complete is the final one when words+1 reaches len.
    assign last_word = (words + LEN_WIDTH'(1)) >= len_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            src_ptr <= '0;
            dst_ptr <= '0;
            len_reg <= '0;
            words   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        src_ptr <= src_addr_i & ALIGN_MASK;
                        dst_ptr <= dst_addr_i & ALIGN_MASK;
                        len_reg <= len_i;
                        words   <= '0;
                    end
                end
                RD: src_ptr <= src_ptr + STEP;
                WR: begin
                    dst_ptr <= dst_ptr + STEP;
                    words   <= words + LEN_WIDTH'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start_i) begin
                    state_next = (len_i != '0) ? RD : FIN;
                end
            end
            RD:      state_next = WR;
            WR:      state_next = last_word ? FIN : RD;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Write data is the RAM's registered read result from the preceding RD cycle.
    always_comb begin
        busy_o      = (state != IDLE);
        done_o      = 1'b0;
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        case (state)
            RD: begin
                mem_en_o   = 1'b1;
                mem_addr_o = src_ptr;
            end
            WR: begin
                mem_en_o    = 1'b1;
                mem_we_o    = 1'b1;
                mem_be_o    = '1;
                mem_addr_o  = dst_ptr;
                mem_wdata_o = mem_rdata_i;
            end
            FIN:     done_o = 1'b1;
            default: ;
        endcase
    end

    assign words_o = words;

endmodule
